// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, the $zero register index and the writeback entry record
package mips_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              live;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular result buffer with per-entry live clear on destination match
module wb_fifo #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [ADDR_W-1:0]             i_push_rd,
    input  logic [DATA_W-1:0]             i_push_data,
    input  logic                          i_push_live,
    input  logic                          i_pop,
    input  logic                          i_squash,
    input  logic [ADDR_W-1:0]             i_squash_rd,
    output logic [ADDR_W-1:0]             o_head_rd,
    output logic [DATA_W-1:0]             o_head_data,
    output logic                          o_head_live,
    output logic [CW-1:0]                 o_count,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [DEPTH-1:0][ADDR_W-1:0]  o_ent_rd,
    output logic [DEPTH-1:0]              o_ent_live
);
    logic [DEPTH-1:0][ADDR_W-1:0] r_rd;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;
    logic [DEPTH-1:0]             r_live;
    logic [DEPTH-1:0]             r_valid;
    logic [PW-1:0]                r_wp;
    logic [PW-1:0]                r_rp;
    logic [CW-1:0]                r_count;
    logic                         w_push;
    logic                         w_pop;

    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign o_count     = r_count;
    assign o_head_rd   = r_rd[r_rp];
    assign o_head_data = r_data[r_rp];
    assign o_head_live = r_live[r_rp];
    assign o_ent_rd    = r_rd;
    assign o_ent_live  = r_valid & r_live;

    // Storage, pointers and count; a squash hits only entries already held, the pushed entry brings its own live bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd    <= '0;
            r_data  <= '0;
            r_live  <= '0;
            r_valid <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (i_squash && r_valid[i] && r_rd[i] == i_squash_rd)
                    r_live[i] <= 1'b0;
            if (w_push) begin
                r_rd[r_wp]    <= i_push_rd;
                r_data[r_wp]  <= i_push_data;
                r_live[r_wp]  <= i_push_live;
                r_valid[r_wp] <= 1'b1;
                r_wp          <= r_wp + PW'(1);
            end
            if (w_pop) begin
                r_valid[r_rp] <= 1'b0;
                r_rp          <= r_rp + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and mul/div results onto the single register-file write port
module regfile_writeback #(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int ADDR_W     = mips_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mul_valid,
    output logic                 mul_ready,
    input  logic [ADDR_W-1:0]    mul_rd,
    input  logic [DATA_W-1:0]    mul_data,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic [2**ADDR_W-1:0] pending_mask,
    output logic [CW-1:0]        fifo_count
);
    logic                               r_wr_en;
    logic [ADDR_W-1:0]                  r_wr_addr;
    logic [DATA_W-1:0]                  r_wr_data;
    logic                               w_alu_hit;
    logic                               w_push;
    logic                               w_pop;
    logic                               w_full;
    logic                               w_empty;
    logic [ADDR_W-1:0]                  w_head_rd;
    logic [DATA_W-1:0]                  w_head_data;
    logic                               w_head_live;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0]  w_ent_rd;
    logic [FIFO_DEPTH-1:0]              w_ent_live;
    logic [2**ADDR_W-1:0]               w_mask;

    assign w_alu_hit = alu_valid && alu_rd != ADDR_W'(mips_pkg::REG_ZERO);
    assign mul_ready = !w_full;
    assign w_push    = mul_valid && !w_full;
    assign w_pop     = !alu_valid && !w_empty;

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_rd   (mul_rd),
        .i_push_data (mul_data),
        .i_push_live (!(w_alu_hit && mul_rd == alu_rd)),
        .i_pop       (w_pop),
        .i_squash    (w_alu_hit),
        .i_squash_rd (alu_rd),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_head_live (w_head_live),
        .o_count     (fifo_count),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_ent_rd    (w_ent_rd),
        .o_ent_live  (w_ent_live)
    );

    // Output stage: ALU has priority, the FIFO head drains into idle cycles, $zero and squashed entries never write
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (alu_valid) begin
            r_wr_en   <= w_alu_hit;
            r_wr_addr <= alu_rd;
            r_wr_data <= alu_data;
        end else if (w_pop) begin
            r_wr_en   <= w_head_live && w_head_rd != ADDR_W'(mips_pkg::REG_ZERO);
            r_wr_addr <= w_head_rd;
            r_wr_data <= w_head_data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    // Pending registers: live queued entries plus the write currently on the port, never $zero
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (w_ent_live[i])
                w_mask[w_ent_rd[i]] = 1'b1;
        if (r_wr_en)
            w_mask[r_wr_addr] = 1'b1;
        w_mask[mips_pkg::REG_ZERO] = 1'b0;
    end

    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign pending_mask = w_mask;
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer-side front end for the 32x32 register file write port (din/writeEnable/rd).
- Merges two result producers into the single write port:
  - the single-cycle ALU pipeline, which is never stalled;
  - the multi-cycle mul/div unit, which uses a valid/ready handshake.
- Mul/div results are buffered in a small FIFO and drained when the ALU leaves the port idle.
- Suppresses writes to $zero, resolves WAW ordering, and exports a pending-register mask for the decode-stage hazard logic.

Parameters:
- DATA_W, 32, data width of a result and of the register-file write data
- ADDR_W, 5, register address width (2**ADDR_W registers)
- FIFO_DEPTH, 4, mul/div result buffer entries (power of two, >= 2)

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-low: sampled on posedge clk, state cleared when rst==0
- alu_valid  input  1  ALU result present this cycle; always accepted
- alu_rd  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- mul_valid  input  1  mul/div result offered
- mul_ready  output  1  buffer can accept; a transfer occurs when mul_valid&&mul_ready
- mul_rd  input  ADDR_W  mul/div destination register
- mul_data  input  DATA_W  mul/div result
- wr_en  output  1  to register file writeEnable
- wr_addr  output  ADDR_W  to register file rd
- wr_data  output  DATA_W  to register file din
- pending_mask  output  2**ADDR_W  bit r=1 while a write to r is queued or in the output stage
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of occupied FIFO entries

Behaviour:
- Reset (rst==0 at posedge): FIFO emptied, all entries invalid. wr_en=0, wr_addr=0, wr_data=0. fifo_count=0, pending_mask=0. mul_ready=1 from the first cycle after reset is released.
- Reset mid-operation discards every queued result. A transfer completed in the same cycle as reset is also lost.
- Output stage: wr_en/wr_addr/wr_data are registered. Latency is exactly 1 cycle from selection to wr_en; the register file captures the write on the following edge.
- Port selection, each cycle:
  - alu_valid=1: ALU wins. Next cycle wr_en=(alu_rd!=0), wr_addr=alu_rd, wr_data=alu_data.
  - alu_valid=0 and FIFO not empty: pop the head. Next cycle wr_en=(head.rd!=0 && head.live), wr_addr=head.rd, wr_data=head.data.
  - Otherwise: wr_en=0. wr_addr/wr_data hold their previous values.
- rd==0 writes are never emitted. A mul entry with rd==0 is still enqueued and popped normally, then silently dropped.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - Each entry holds {rd, data, live}.
  - mul_ready = (fifo_count < FIFO_DEPTH), computed from the current count. No push when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave fifo_count unchanged.
- WAW squash:
  - When alu_valid && alu_rd!=0, every valid FIFO entry with rd==alu_rd has live cleared in that cycle.
  - A mul transfer in the same cycle with mul_rd==alu_rd is treated as older: it is enqueued with live=0.
  - Squashed entries still occupy a slot and still count in fifo_count until popped.
- pending_mask (combinational from state):
  - bit r = OR over valid live FIFO entries with rd==r, OR (wr_en && wr_addr==r).
  - Bit 0 is always 0.
- No state machine beyond the FIFO pointers and count. Counters saturate by construction: no push when full, no pop when empty.

Decomposition:
- Shared package mips_pkg holds DATA_W, ADDR_W, REG_ZERO=0, and the wb_entry record {rd, data, live}.
- One natural sub-module: wb_fifo, a parameterised circular buffer with per-entry live clear by address match, exposing head, count, full, empty and a per-entry rd/live view for pending_mask.
- Top level holds the arbitration, the output register and the mask reduction.

Test Plan:
- Reset: drive rst=0 for 2 cycles with mul_valid=1 -> wr_en=0, fifo_count=0, pending_mask=0, no transfer retained. After release: mul_ready=1.
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF -> next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF. With rd=0 -> wr_en=0.
- Mul drain: 3 mul pushes (rd 7,8,9; data 1,2,3) while alu_valid=1 for 3 cycles:
  - fifo_count=3, pending_mask bits 7,8,9 set;
  - after alu_valid drops, writes 7/1, 8/2, 9/3 appear on consecutive cycles and fifo_count returns to 0.
- Full/backpressure: hold alu_valid=1 and push 4 mul results:
  - mul_ready=0 and fifo_count=4;
  - a 5th offered result is not accepted until one cycle after the first pop.
- WAW squash: queue mul rd=10 data=0x11, then alu rd=10 data=0x22 -> ALU write 10/0x22 emitted; on pop, the mul entry gives wr_en=0; register 10 ends at 0x22; pending_mask[10] clears.
- Simultaneous same-rd: mul and alu both valid with rd=12 in the same cycle -> only 12/alu_data is written; fifo_count increments by 1 and that entry is dropped when popped.
